// File: rtl/uart_rx_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// uart_rx_ctrl_pkg
// Shared definitions for the UART receive controller:
//   - controller FSM state encoding (ctrl_state_t)
//   - receiver idle code (rx_state[2:0] == RX_IDLE means the receiver is idle)
//   - FIFO entry layout {noise, stop_err, parity_err, rx_parity, byte[7:0]}
//   - reset value of the shadow baud divisor
// ----------------------------------------------------------------------------
package uart_rx_ctrl_pkg;

   localparam int ENTRY_W    = 12;
   localparam int E_NOISE    = 11;
   localparam int E_STOP_ERR = 10;
   localparam int E_PAR_ERR  = 9;
   localparam int E_PARITY   = 8;

   localparam logic [2:0]  RX_IDLE  = 3'd0;
   localparam logic [15:0] BAUD_RST = 16'd16;

   typedef enum logic [1:0] {
      CTRL_OFF   = 2'd0,
      CTRL_ARM   = 2'd1,
      CTRL_RUN   = 2'd2,
      CTRL_DRAIN = 2'd3
   } ctrl_state_t;

   function automatic logic [ENTRY_W-1:0] pack_entry(input logic       noise,
                                                     input logic       stop_err,
                                                     input logic       parity_err,
                                                     input logic       parity,
                                                     input logic [7:0] data);
      logic [ENTRY_W-1:0] e;
      e             = '0;
      e[7:0]        = data;
      e[E_PARITY]   = parity;
      e[E_PAR_ERR]  = parity_err;
      e[E_STOP_ERR] = stop_err;
      e[E_NOISE]    = noise;
      return e;
   endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// ----------------------------------------------------------------------------
// uart_rx_fifo
// Synchronous show-ahead FIFO holding assembled receive entries.
// Ports:
//   clk, rstn      clock, asynchronous active-low reset
//   wr, din        write request / data; accepted when not full, or when full
//                  and a read happens in the same cycle
//   rd             read (pop) request; ignored when empty
//   dout           head entry, 0 when empty
//   level          number of entries (AW+1 bits)
//   full, empty    status
// ----------------------------------------------------------------------------
module uart_rx_fifo #(
   parameter int AW = 3,
   parameter int DW = 12
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          wr,
   input  logic [DW-1:0] din,
   input  logic          rd,
   output logic [DW-1:0] dout,
   output logic [AW:0]   level,
   output logic          full,
   output logic          empty
);

   localparam int DEPTH = 1 << AW;

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          wr_ok;
   logic          rd_ok;

   assign full  = (level == (AW+1)'(DEPTH));
   assign empty = (level == '0);
   assign rd_ok = rd && !empty;
   // a full FIFO still accepts a write when the head leaves in the same cycle
   assign wr_ok = wr && (!full || rd_ok);
   assign dout  = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (wr_ok) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
         if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
         case ({wr_ok, rd_ok})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/uart_rx_ctrl.sv
// ----------------------------------------------------------------------------
// uart_rx_ctrl
// Controller sitting above uart_receiver. Sequences rx_en, owns the shadow
// frame configuration (only changed while the receiver is idle), assembles
// each frame plus its late error/noise flags into one FIFO entry, and raises
// threshold / character-timeout / overflow interrupts.
//
// Optional feature macro: UART_RX_CTRL_ERR_DROP_EN
//   defined   : frames with parity or stop error are dropped and counted in
//               err_drop_cnt (saturating at 255)
//   undefined : every frame is written with its flags, err_drop_cnt = 0
//
// Ports:
//   clk, rstn                   clock, asynchronous active-low reset
//   sw_rx_en                    host receive enable (level)
//   cfg_update_p, cfg_*         shadow config reload pulse and source values
//   cfg_thresh                  FIFO level interrupt threshold (0 disables)
//   rx_en, baud_rate, word_len, parity_en, parity_type, stop_len
//                               shadow config driving the receiver
//   rx_vld_p, rx_byte, rx_parity, *_noise_p, parity_err_p, stop_err_p, rx_state
//                               receiver status inputs
//   rd_en, rd_data              host pop / head entry
//   fifo_empty, fifo_full, fifo_level
//   ovf_sticky, ovf_clr         dropped-commit flag and its clear
//   tout_flag, rx_irq           character timeout and combined interrupt
//   err_drop_cnt                dropped error frame count
//   ctrl_state                  controller FSM state
//
// state | meaning
// OFF   | receiver disabled, waiting for sw_rx_en
// ARM   | load shadow config from cfg_* once the receiver is idle
// RUN   | receiving; config updates deferred to idle cycles
// DRAIN | sw_rx_en dropped, letting the current frame finish
// ----------------------------------------------------------------------------
module uart_rx_ctrl
   import uart_rx_ctrl_pkg::*;
#(
   parameter int AW        = 3,
   parameter int TOUT_BITS = 40
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic                sw_rx_en,
   input  logic                cfg_update_p,
   input  logic [15:0]         cfg_baud_rate,
   input  logic                cfg_word_len,
   input  logic                cfg_parity_en,
   input  logic                cfg_parity_type,
   input  logic [1:0]          cfg_stop_len,
   input  logic [AW:0]         cfg_thresh,
   output logic                rx_en,
   output logic [15:0]         baud_rate,
   output logic                word_len,
   output logic                parity_en,
   output logic                parity_type,
   output logic [1:0]          stop_len,
   input  logic                rx_vld_p,
   input  logic [7:0]          rx_byte,
   input  logic                rx_parity,
   input  logic                start_noise_p,
   input  logic                data_noise_p,
   input  logic                parity_noise_p,
   input  logic                stop_noise_p,
   input  logic                parity_err_p,
   input  logic                stop_err_p,
   input  logic [7:0]          rx_state,
   input  logic                rd_en,
   output logic [ENTRY_W-1:0]  rd_data,
   output logic                fifo_empty,
   output logic                fifo_full,
   output logic [AW:0]         fifo_level,
   output logic                ovf_sticky,
   input  logic                ovf_clr,
   output logic                tout_flag,
   output logic                rx_irq,
   output logic [7:0]          err_drop_cnt,
   output logic [1:0]          ctrl_state
);

   localparam int TW = $clog2(TOUT_BITS + 1);

   ctrl_state_t        st;
   logic               cfg_pend;
   logic               rx_idle;
   logic               unused_rx_state_hi;

   logic               prev_busy;
   logic               pend;
   logic [7:0]         pend_byte;
   logic               acc_perr;
   logic               acc_serr;
   logic               acc_noise;
   logic               noise_now;
   logic               commit;
   logic [ENTRY_W-1:0] commit_entry;
   logic               fifo_wr;
   logic               pop;
   logic               ovf_set;

   logic [15:0]        bit_period;
   logic [15:0]        tick_rld;
   logic [15:0]        tick_cnt;
   logic [TW-1:0]      idle_cnt;
   logic               tick;
   logic               tclr;

   assign rx_idle            = (rx_state[2:0] == RX_IDLE);
   assign unused_rx_state_hi = |rx_state[7:3];
   assign ctrl_state         = st;

   // ---------------- controller FSM and shadow configuration ----------------
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         st          <= CTRL_OFF;
         rx_en       <= 1'b0;
         cfg_pend    <= 1'b0;
         baud_rate   <= BAUD_RST;
         word_len    <= 1'b0;
         parity_en   <= 1'b0;
         parity_type <= 1'b0;
         stop_len    <= 2'd0;
      end else begin
         if (cfg_update_p) cfg_pend <= 1'b1;
         case (st)
            CTRL_OFF: begin
               if (sw_rx_en) st <= CTRL_ARM;
            end
            CTRL_ARM: begin
               // rx_en is left as is here so a reconfiguration from RUN does
               // not glitch the receiver enable
               if (rx_idle) begin
                  baud_rate   <= cfg_baud_rate;
                  word_len    <= cfg_word_len;
                  parity_en   <= cfg_parity_en;
                  parity_type <= cfg_parity_type;
                  stop_len    <= cfg_stop_len;
                  cfg_pend    <= 1'b0;
                  rx_en       <= 1'b1;
                  st          <= CTRL_RUN;
               end
            end
            CTRL_RUN: begin
               if (!sw_rx_en)
                  st <= CTRL_DRAIN;
               else if (rx_idle && (cfg_update_p || cfg_pend))
                  st <= CTRL_ARM;
            end
            CTRL_DRAIN: begin
               if (sw_rx_en) begin
                  st <= CTRL_RUN;
               end else if (rx_idle) begin
                  st    <= CTRL_OFF;
                  rx_en <= 1'b0;
               end
            end
            default: st <= CTRL_OFF;
         endcase
      end
   end

   // ---------------- frame assembly ----------------
   assign noise_now = start_noise_p | data_noise_p | parity_noise_p | stop_noise_p;
   // the receiver dropping back to idle marks the end of the frame
   assign commit    = pend && prev_busy && rx_idle;
   // flags pulsing in the commit cycle itself still belong to this frame
   assign commit_entry = pack_entry(acc_noise | noise_now,
                                    acc_serr  | stop_err_p,
                                    acc_perr  | parity_err_p,
                                    rx_parity, pend_byte);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         prev_busy <= 1'b0;
         pend      <= 1'b0;
         pend_byte <= 8'd0;
         acc_perr  <= 1'b0;
         acc_serr  <= 1'b0;
         acc_noise <= 1'b0;
      end else begin
         prev_busy <= !rx_idle;
         if (commit || (rx_idle && !pend && !rx_vld_p)) begin
            // start noise arrives before rx_vld_p, so accumulation is keyed
            // on receiver activity as well as pend
            acc_perr  <= 1'b0;
            acc_serr  <= 1'b0;
            acc_noise <= 1'b0;
         end else begin
            acc_perr  <= acc_perr  | parity_err_p;
            acc_serr  <= acc_serr  | stop_err_p;
            acc_noise <= acc_noise | noise_now;
         end
         if (commit) pend <= 1'b0;
         if (rx_vld_p) begin
            pend      <= 1'b1;
            pend_byte <= rx_byte;
         end
      end
   end

`ifdef UART_RX_CTRL_ERR_DROP_EN
   logic err_frame;
   assign err_frame = commit_entry[E_PAR_ERR] | commit_entry[E_STOP_ERR];
   assign fifo_wr   = commit && !err_frame;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         err_drop_cnt <= 8'd0;
      else if (commit && err_frame && (err_drop_cnt != 8'hFF))
         err_drop_cnt <= err_drop_cnt + 8'd1;
   end
`else
   assign fifo_wr      = commit;
   assign err_drop_cnt = 8'd0;
`endif

   // ---------------- FIFO ----------------
   uart_rx_fifo #(
      .AW (AW),
      .DW (ENTRY_W)
   ) u_fifo (
      .clk   (clk),
      .rstn  (rstn),
      .wr    (fifo_wr),
      .din   (commit_entry),
      .rd    (rd_en),
      .dout  (rd_data),
      .level (fifo_level),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign pop     = rd_en && !fifo_empty;
   assign ovf_set = fifo_wr && fifo_full && !rd_en;

   // ---------------- character timeout ----------------
   assign bit_period = {baud_rate[15:4], 4'd0} + {12'd0, baud_rate[3:0]};
   assign tick_rld   = (bit_period == 16'd0) ? 16'd0 : bit_period - 16'd1;
   assign tick       = (tick_cnt == 16'd0);
   assign tclr       = !rx_idle || commit || pop || fifo_empty;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         tick_cnt  <= 16'd0;
         idle_cnt  <= TW'(TOUT_BITS);
         tout_flag <= 1'b0;
      end else begin
         if (tclr) begin
            tick_cnt <= tick_rld;
            idle_cnt <= TW'(TOUT_BITS);
         end else if (tick) begin
            tick_cnt <= tick_rld;
            if (idle_cnt != '0) idle_cnt <= idle_cnt - 1'b1;
         end else begin
            tick_cnt <= tick_cnt - 16'd1;
         end

         if (pop || commit)
            tout_flag <= 1'b0;
         else if (!tclr && tick && (idle_cnt == TW'(1)))
            tout_flag <= 1'b1;
      end
   end

   // ---------------- overflow and interrupt ----------------
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ovf_sticky <= 1'b0;
         rx_irq     <= 1'b0;
      end else begin
         if (ovf_set)
            ovf_sticky <= 1'b1;
         else if (ovf_clr)
            ovf_sticky <= 1'b0;
         rx_irq <= ((fifo_level >= cfg_thresh) && (cfg_thresh != '0))
                   || tout_flag || ovf_sticky;
      end
   end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// ----------------------------------------------------------------------------
// tb_uart_rx_ctrl
// Directed bench for uart_rx_ctrl. A small receiver model drives rx_state and
// the frame pulses; expected values are hand-computed constants.
// ----------------------------------------------------------------------------
module tb_uart_rx_ctrl;

   localparam int AW = 3;

   logic        clk = 1'b0;
   logic        rstn;
   logic        sw_rx_en;
   logic        cfg_update_p;
   logic [15:0] cfg_baud_rate;
   logic        cfg_word_len;
   logic        cfg_parity_en;
   logic        cfg_parity_type;
   logic [1:0]  cfg_stop_len;
   logic [AW:0] cfg_thresh;
   logic        rx_en;
   logic [15:0] baud_rate;
   logic        word_len;
   logic        parity_en;
   logic        parity_type;
   logic [1:0]  stop_len;
   logic        rx_vld_p;
   logic [7:0]  rx_byte;
   logic        rx_parity;
   logic        start_noise_p;
   logic        data_noise_p;
   logic        parity_noise_p;
   logic        stop_noise_p;
   logic        parity_err_p;
   logic        stop_err_p;
   logic [7:0]  rx_state;
   logic        rd_en;
   logic [11:0] rd_data;
   logic        fifo_empty;
   logic        fifo_full;
   logic [AW:0] fifo_level;
   logic        ovf_sticky;
   logic        ovf_clr;
   logic        tout_flag;
   logic        rx_irq;
   logic [7:0]  err_drop_cnt;
   logic [1:0]  ctrl_state;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   uart_rx_ctrl #(.AW(AW), .TOUT_BITS(40)) dut (
      .clk             (clk),
      .rstn            (rstn),
      .sw_rx_en        (sw_rx_en),
      .cfg_update_p    (cfg_update_p),
      .cfg_baud_rate   (cfg_baud_rate),
      .cfg_word_len    (cfg_word_len),
      .cfg_parity_en   (cfg_parity_en),
      .cfg_parity_type (cfg_parity_type),
      .cfg_stop_len    (cfg_stop_len),
      .cfg_thresh      (cfg_thresh),
      .rx_en           (rx_en),
      .baud_rate       (baud_rate),
      .word_len        (word_len),
      .parity_en       (parity_en),
      .parity_type     (parity_type),
      .stop_len        (stop_len),
      .rx_vld_p        (rx_vld_p),
      .rx_byte         (rx_byte),
      .rx_parity       (rx_parity),
      .start_noise_p   (start_noise_p),
      .data_noise_p    (data_noise_p),
      .parity_noise_p  (parity_noise_p),
      .stop_noise_p    (stop_noise_p),
      .parity_err_p    (parity_err_p),
      .stop_err_p      (stop_err_p),
      .rx_state        (rx_state),
      .rd_en           (rd_en),
      .rd_data         (rd_data),
      .fifo_empty      (fifo_empty),
      .fifo_full       (fifo_full),
      .fifo_level      (fifo_level),
      .ovf_sticky      (ovf_sticky),
      .ovf_clr         (ovf_clr),
      .tout_flag       (tout_flag),
      .rx_irq          (rx_irq),
      .err_drop_cnt    (err_drop_cnt),
      .ctrl_state      (ctrl_state)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // mode 0: plain frame; 1: cfg_update_p with new baud mid-frame;
   // 2: sw_rx_en dropped mid-frame
   task automatic send_frame(input logic [7:0] b, input logic perr, input logic serr,
                             input logic snoise, input logic par, input logic pop_c,
                             input int mode);
      @(negedge clk) rx_state = 8'd1; start_noise_p = snoise;
      @(negedge clk) start_noise_p = 1'b0; rx_state = 8'd2;
      if (mode == 1) begin
         cfg_baud_rate = 16'h0100;
         cfg_update_p  = 1'b1;
      end
      if (mode == 2) sw_rx_en = 1'b0;
      @(negedge clk) cfg_update_p = 1'b0; rx_vld_p = 1'b1; rx_byte = b;
      @(negedge clk) rx_vld_p = 1'b0; rx_state = 8'd3; parity_err_p = perr;
      if (mode == 2) begin
         check("drain_state", ctrl_state, 32'd3);
         check("drain_rx_en", rx_en, 32'd1);
      end
      @(negedge clk) parity_err_p = 1'b0; rx_state = 8'd4; stop_err_p = serr; rx_parity = par;
      if (mode == 1) check("baud_hold_midframe", baud_rate, 32'd16);
      @(negedge clk) stop_err_p = 1'b0; rx_state = 8'd0; rd_en = pop_c;
      @(negedge clk) rd_en = 1'b0;
   endtask

   task automatic pop_one();
      @(negedge clk) rd_en = 1'b1;
      @(negedge clk) rd_en = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [11:0] exp_q;
      rstn = 1'b0; sw_rx_en = 1'b0; cfg_update_p = 1'b0;
      cfg_baud_rate = 16'd16; cfg_word_len = 1'b1; cfg_parity_en = 1'b0;
      cfg_parity_type = 1'b0; cfg_stop_len = 2'd0; cfg_thresh = 4'd4;
      rx_vld_p = 1'b0; rx_byte = 8'd0; rx_parity = 1'b0;
      start_noise_p = 1'b0; data_noise_p = 1'b0; parity_noise_p = 1'b0; stop_noise_p = 1'b0;
      parity_err_p = 1'b0; stop_err_p = 1'b0; rx_state = 8'd0;
      rd_en = 1'b0; ovf_clr = 1'b0;
      repeat (3) @(negedge clk);
      rstn = 1'b1;

      // reset values
      check("rst_rx_en", rx_en, 32'd0);
      check("rst_baud", baud_rate, 32'd16);
      check("rst_empty", fifo_empty, 32'd1);
      check("rst_level", fifo_level, 32'd0);
      check("rst_rd_data", rd_data, 32'd0);
      check("rst_state", ctrl_state, 32'd0);
      check("rst_irq", rx_irq, 32'd0);
      check("rst_ovf", ovf_sticky, 32'd0);

      // enable: ARM after one edge, RUN with rx_en after the second
      sw_rx_en = 1'b1;
      @(negedge clk);
      check("arm_state", ctrl_state, 32'd1);
      check("arm_rx_en", rx_en, 32'd0);
      @(negedge clk);
      check("run_state", ctrl_state, 32'd2);
      check("run_rx_en", rx_en, 32'd1);
      check("run_word_len", word_len, 32'd1);

      // 8N1 frame 0xA5
      send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      check("a5_level", fifo_level, 32'd1);
      check("a5_data", rd_data, 32'h0A5);
      check("a5_empty", fifo_empty, 32'd0);
      pop_one();
      check("a5_pop_level", fifo_level, 32'd0);
      check("a5_pop_data", rd_data, 32'd0);

      // pop on empty has no effect
      pop_one();
      check("empty_pop_level", fifo_level, 32'd0);
      check("empty_pop_empty", fifo_empty, 32'd1);

      // reconfigure to 8E1 while idle
      cfg_parity_en = 1'b1;
      @(negedge clk) cfg_update_p = 1'b1;
      @(negedge clk) cfg_update_p = 1'b0;
      @(negedge clk);
      check("cfg_parity_en", parity_en, 32'd1);
      check("cfg_state_run", ctrl_state, 32'd2);

      // wrong parity frame 0x3C, rx_parity=1
      send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0);
`ifdef UART_RX_CTRL_ERR_DROP_EN
      check("perr_drop_level", fifo_level, 32'd0);
      check("perr_drop_cnt", err_drop_cnt, 32'd1);
`else
      check("perr_level", fifo_level, 32'd1);
      check("perr_data", rd_data, 32'h33C);
      check("perr_drop_cnt", err_drop_cnt, 32'd0);
      pop_one();
`endif

      // start-bit noise lands in the entry of the same frame
      send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
      check("noise_data", rd_data, 32'h85A);
      pop_one();

      // fill the FIFO
      for (int i = 0; i < 8; i++)
         send_frame(8'(8'h10 + i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      check("full_level", fifo_level, 32'd8);
      check("full_flag", fifo_full, 32'd1);
      check("full_no_ovf", ovf_sticky, 32'd0);
      check("full_head", rd_data, 32'h010);
      check("full_irq", rx_irq, 32'd1);

      // ninth frame is dropped
      send_frame(8'h18, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      check("ovf_level", fifo_level, 32'd8);
      check("ovf_set", ovf_sticky, 32'd1);
      @(negedge clk) ovf_clr = 1'b1;
      @(negedge clk) ovf_clr = 1'b0;
      check("ovf_clr", ovf_sticky, 32'd0);

      // commit and pop together while full
      send_frame(8'h19, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
      check("cpop_level", fifo_level, 32'd8);
      check("cpop_no_ovf", ovf_sticky, 32'd0);
      check("cpop_head", rd_data, 32'h011);

      for (int i = 0; i < 8; i++) begin
         exp_q = (i < 7) ? 12'(12'h011 + i) : 12'h019;
         check("drain_order", rd_data, 32'(exp_q));
         pop_one();
      end
      check("drained_empty", fifo_empty, 32'd1);
      @(negedge clk);
      check("drained_irq", rx_irq, 32'd0);

      // config update mid-frame is deferred until the receiver is idle
      send_frame(8'h77, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
      @(negedge clk);
      @(negedge clk);
      check("baud_updated", baud_rate, 32'h0100);
      check("upd_state_run", ctrl_state, 32'd2);
      pop_one();

      // character timeout: 40 bit-times of 256 clocks after the commit
      send_frame(8'h42, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      repeat (10230) @(negedge clk);
      check("tout_early", tout_flag, 32'd0);
      repeat (12) @(negedge clk);
      check("tout_set", tout_flag, 32'd1);
      check("tout_irq", rx_irq, 32'd1);
      pop_one();
      check("tout_pop_clr", tout_flag, 32'd0);
      @(negedge clk);
      check("tout_irq_clr", rx_irq, 32'd0);

      // disable mid-frame: drain, commit, then OFF
      send_frame(8'h99, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2);
      check("off_state", ctrl_state, 32'd0);
      check("off_rx_en", rx_en, 32'd0);
      check("off_level", fifo_level, 32'd1);
      check("off_data", rd_data, 32'h099);
      repeat (5) @(negedge clk);
      check("off_no_flush", fifo_level, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
